// File: rtl/turf_bus_regif_v3.sv
`timescale 1ns/1ps
// turf_bus_regif_v3
// Byte-serial (parametrised beat width) register bus slave for the TURFIO
// chip-select / write-not-read bus. Decodes single and burst transfers and
// presents a register-file strobe interface to downstream banks.
//
// Transaction format on the bus (one beat per clock while cs_n_i is low):
//   first beat    : register address (low ADDR_WIDTH bits)
//   write beats   : WORD_WIDTH/BUS_WIDTH beats per word, LSB beat first;
//                   the address auto-increments after every complete word
//   read          : one request cycle, one turnaround cycle, then the word
//                   LSB beat first; holding cs low reads the next address
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   cs_n_i, wnr_i         bus chip select (active low), 1=write / 0=read
//   bus_di_i              incoming bus beat
//   bus_do_o, bus_oe_o    outgoing bus beat and its drive enable
//   wr_stb_o/_addr/_data  one-cycle write strobe with address and word
//   rd_stb_o/_addr        one-cycle read request with address
//   rd_data_i             read data, valid the cycle after rd_stb_o
//   state_o               FSM state for debug
module turf_bus_regif_v3 #(
  parameter int                    BUS_WIDTH  = 8,
  parameter int                    WORD_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [WORD_WIDTH-1:0] IDENT      = "TURF",
  parameter logic [WORD_WIDTH-1:0] VERSION    = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cs_n_i,
  input  logic                  wnr_i,
  input  logic [BUS_WIDTH-1:0]  bus_di_i,
  output logic [BUS_WIDTH-1:0]  bus_do_o,
  output logic                  bus_oe_o,
  output logic                  wr_stb_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [WORD_WIDTH-1:0] wr_data_o,
  output logic                  rd_stb_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [WORD_WIDTH-1:0] rd_data_i,
  output logic [2:0]            state_o
);

  // WORD_WIDTH must be a multiple of BUS_WIDTH with at least two beats,
  // and the address must fit in a single beat.
  localparam int NBEATS = WORD_WIDTH / BUS_WIDTH;
  localparam int BEAT_W = $clog2(NBEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WDATA = 3'd1,
    RREQ  = 3'd2,
    RWAIT = 3'd3,
    RDATA = 3'd4
  } state_t;

  logic                  cs_q;
  logic                  wnr_q;
  logic [BUS_WIDTH-1:0]  di_q;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BEAT_W-1:0]     beat_q;
  logic [WORD_WIDTH-1:0] word_q;
  logic [WORD_WIDTH-1:0] word_asm;
  logic [WORD_WIDTH-1:0] shift_q;
  logic [WORD_WIDTH-1:0] rd_word;
  logic                  oe_q;
  logic                  wr_stb_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [WORD_WIDTH-1:0] wr_data_q;

  // ---- input stage: every bus input is registered once ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cs_q  <= 1'b1;
      wnr_q <= 1'b1;
      di_q  <= '0;
    end else begin
      cs_q  <= cs_n_i;
      wnr_q <= wnr_i;
      di_q  <= bus_di_i;
    end
  end

  // ---- decode stage: FSM next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!cs_q) state_d = wnr_q ? WDATA : RREQ;
      end
      WDATA: begin
        if (cs_q) state_d = IDLE;
      end
      RREQ: begin
        state_d = cs_q ? IDLE : RWAIT;
      end
      RWAIT: begin
        state_d = cs_q ? IDLE : RDATA;
      end
      RDATA: begin
        if (cs_q)                     state_d = IDLE;
        else if (beat_q == LAST_BEAT) state_d = RREQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // Current write word with the incoming beat merged into its slot, so the
  // strobe can present the full word on the same edge as the last beat.
  always_comb begin
    word_asm = word_q;
    for (int b = 0; b < NBEATS; b++) begin
      if (beat_q == BEAT_W'(b)) word_asm[b*BUS_WIDTH +: BUS_WIDTH] = di_q;
    end
  end

  // Addresses 0 and 1 are answered locally; the request still goes out.
  always_comb begin
    rd_word = rd_data_i;
    if (addr_q == '0)                   rd_word = IDENT;
    else if (addr_q == ADDR_WIDTH'(1))  rd_word = VERSION;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---- transfer stage: address, beat counter, word and shift registers ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q    <= '0;
      beat_q    <= '0;
      word_q    <= '0;
      shift_q   <= '0;
      oe_q      <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_stb_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!cs_q) begin
            addr_q <= di_q[ADDR_WIDTH-1:0];
            beat_q <= '0;
          end
        end
        WDATA: begin
          if (!cs_q) begin
            word_q <= word_asm;
            if (beat_q == LAST_BEAT) begin
              wr_stb_q  <= 1'b1;
              wr_addr_q <= addr_q;
              wr_data_q <= word_asm;
              addr_q    <= addr_q + ADDR_WIDTH'(1);
              beat_q    <= '0;
            end else begin
              beat_q <= beat_q + BEAT_W'(1);
            end
          end
        end
        RREQ: begin
          // Turnaround: start driving one cycle before the first beat.
          oe_q <= !cs_q;
        end
        RWAIT: begin
          if (cs_q) begin
            oe_q <= 1'b0;
          end else begin
            shift_q <= rd_word;
            beat_q  <= '0;
          end
        end
        RDATA: begin
          // Zero-fill on shift leaves the bus at 0 through the burst gap.
          shift_q <= shift_q >> BUS_WIDTH;
          if (cs_q) begin
            oe_q    <= 1'b0;
            shift_q <= '0;
          end else if (beat_q == LAST_BEAT) begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
            beat_q <= '0;
          end else begin
            beat_q <= beat_q + BEAT_W'(1);
          end
        end
        default: begin
          oe_q    <= 1'b0;
          shift_q <= '0;
        end
      endcase
    end
  end

  assign bus_do_o  = shift_q[BUS_WIDTH-1:0];
  assign bus_oe_o  = oe_q;
  assign wr_stb_o  = wr_stb_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  // The request cycle is exactly the cycle spent in RREQ.
  assign rd_stb_o  = (state_q == RREQ);
  assign rd_addr_o = addr_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_turf_bus_regif_v3.sv
`timescale 1ns/1ps
module tb_turf_bus_regif_v3;

  logic        clk_i;
  logic        rst_i;
  logic        cs_n_i;
  logic        wnr_i;
  logic [7:0]  bus_di_i;
  logic [7:0]  bus_do_o;
  logic        bus_oe_o;
  logic        wr_stb_o;
  logic [7:0]  wr_addr_o;
  logic [31:0] wr_data_o;
  logic        rd_stb_o;
  logic [7:0]  rd_addr_o;
  logic [31:0] rd_data_i;
  logic [2:0]  state_o;

  turf_bus_regif_v3 #(
    .BUS_WIDTH (8),
    .WORD_WIDTH(32),
    .ADDR_WIDTH(8),
    .IDENT     (32'h54555246),
    .VERSION   (32'h0)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .cs_n_i   (cs_n_i),
    .wnr_i    (wnr_i),
    .bus_di_i (bus_di_i),
    .bus_do_o (bus_do_o),
    .bus_oe_o (bus_oe_o),
    .wr_stb_o (wr_stb_o),
    .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o),
    .rd_stb_o (rd_stb_o),
    .rd_addr_o(rd_addr_o),
    .rd_data_i(rd_data_i),
    .state_o  (state_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int          n_chk = 0;
  int          n_bad = 0;
  logic [31:0] mem [256];
  logic [7:0]  wbeat [16];
  logic        pend;
  logic [7:0]  pend_addr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp_v);
    end
  endtask

  // Word the slave side should return for an address, including the two
  // locally answered identification registers.
  function automatic logic [31:0] exp_word(input logic [7:0] a);
    if (a == 8'd0) return 32'h54555246;
    if (a == 8'd1) return 32'h0;
    return mem[a];
  endfunction

  // Advance one clock and act as the register bank: data is valid only in
  // the cycle right after a request, random junk otherwise.
  task automatic tick();
    @(posedge clk_i);
    #1;
    if (pend) rd_data_i = mem[pend_addr];
    else      rd_data_i = $urandom;
    pend      = rd_stb_o;
    pend_addr = rd_addr_o;
  endtask

  task automatic idle(input int n);
    cs_n_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      check_eq("idle_oe", {31'd0, bus_oe_o}, 32'd0);
      check_eq("idle_wr_stb", {31'd0, wr_stb_o}, 32'd0);
      check_eq("idle_rd_stb", {31'd0, rd_stb_o}, 32'd0);
      check_eq("idle_do", {24'd0, bus_do_o}, 32'd0);
      wnr_i    = 1'(2'($urandom));
      bus_di_i = 8'($urandom);
    end
  endtask

  // Write transaction: address beat, nb data beats from wbeat[], then cs high.
  // Every complete group of four beats yields one strobe; a trailing partial
  // group is dropped.
  task automatic run_write(input logic [7:0] a, input int nb);
    int          nw;
    int          wi;
    logic        e_stb;
    logic [31:0] e_word;
    nw = nb / 4;
    cs_n_i = 1'b0; wnr_i = 1'b1; bus_di_i = a;
    for (int r = 1; r <= nb + 6; r++) begin
      tick();
      e_stb = 1'b0;
      wi    = (r - 6) / 4;
      if (r >= 6 && ((r - 6) % 4) == 0 && wi < nw) e_stb = 1'b1;
      check_eq("wr_stb", {31'd0, wr_stb_o}, {31'd0, e_stb});
      if (e_stb) begin
        e_word = 32'(wbeat[4*wi]) + (32'(wbeat[4*wi+1]) << 8) +
                 (32'(wbeat[4*wi+2]) << 16) + (32'(wbeat[4*wi+3]) << 24);
        check_eq("wr_addr", {24'd0, wr_addr_o}, {24'd0, 8'(a + 8'(wi))});
        check_eq("wr_data", wr_data_o, e_word);
      end
      check_eq("wr_oe", {31'd0, bus_oe_o}, 32'd0);
      wnr_i = 1'(2'($urandom));
      if (r <= nb) begin
        bus_di_i = wbeat[r-1];
      end else begin
        cs_n_i   = 1'b1;
        bus_di_i = 8'($urandom);
      end
    end
    check_eq("wr_end_state", {29'd0, state_o}, 32'd0);
  endtask

  // Read transaction: cs held low through drive d-1. Each word occupies six
  // cycles: request, turnaround, four beats. Everything stops at relative
  // cycle d+2, the first one where the slave has seen cs high.
  task automatic run_read(input logic [7:0] a, input int d);
    int          k;
    int          w;
    logic        e_stb;
    logic        e_oe;
    logic [7:0]  e_do;
    cs_n_i = 1'b0; wnr_i = 1'b0; bus_di_i = a;
    for (int r = 1; r <= d + 4; r++) begin
      tick();
      e_stb = 1'b0; e_oe = 1'b0; e_do = 8'd0;
      k = (r - 2) % 6;
      w = (r - 2) / 6;
      if (r >= 2 && r < d + 2) begin
        if (k == 0) begin
          e_stb = 1'b1;
          e_oe  = (w > 0);
        end else if (k == 1) begin
          e_oe = 1'b1;
        end else begin
          e_oe = 1'b1;
          e_do = 8'(exp_word(8'(a + 8'(w))) >> (8 * (k - 2)));
        end
      end
      check_eq("rd_stb", {31'd0, rd_stb_o}, {31'd0, e_stb});
      if (e_stb) check_eq("rd_addr", {24'd0, rd_addr_o}, {24'd0, 8'(a + 8'(w))});
      check_eq("rd_oe", {31'd0, bus_oe_o}, {31'd0, e_oe});
      check_eq("rd_do", {24'd0, bus_do_o}, {24'd0, e_do});
      check_eq("rd_wr_stb", {31'd0, wr_stb_o}, 32'd0);
      wnr_i    = 1'(2'($urandom));
      bus_di_i = 8'($urandom);
      if (r >= d) cs_n_i = 1'b1;
    end
    check_eq("rd_end_state", {29'd0, state_o}, 32'd0);
  endtask

  // Reset pulled in the middle of the third data beat of a read.
  task automatic read_reset(input logic [7:0] a);
    cs_n_i = 1'b0; wnr_i = 1'b0; bus_di_i = a;
    for (int r = 1; r <= 6; r++) begin
      tick();
      if (r == 2) check_eq("rr_stb", {31'd0, rd_stb_o}, 32'd1);
      bus_di_i = 8'($urandom);
    end
    check_eq("rr_beat2", {24'd0, bus_do_o}, {24'd0, 8'(exp_word(a) >> 16)});
    rst_i = 1'b1;
    #1;
    check_eq("rr_oe", {31'd0, bus_oe_o}, 32'd0);
    check_eq("rr_state", {29'd0, state_o}, 32'd0);
    check_eq("rr_do", {24'd0, bus_do_o}, 32'd0);
    check_eq("rr_rd_stb", {31'd0, rd_stb_o}, 32'd0);
    cs_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rr_hold_oe", {31'd0, bus_oe_o}, 32'd0);
      check_eq("rr_hold_stb", {30'd0, rd_stb_o, wr_stb_o}, 32'd0);
    end
    rst_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int kind;
    int nw;
    int d;
    logic [7:0] a;
    rst_i = 1'b1; cs_n_i = 1'b1; wnr_i = 1'b1; bus_di_i = 8'd0;
    rd_data_i = 32'd0; pend = 1'b0; pend_addr = 8'd0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h10] = 32'hA5A5A5A5;
    mem[8'h11] = 32'h5A5A5A5A;

    repeat (3) tick();
    check_eq("rst_oe", {31'd0, bus_oe_o}, 32'd0);
    check_eq("rst_do", {24'd0, bus_do_o}, 32'd0);
    check_eq("rst_wr_stb", {31'd0, wr_stb_o}, 32'd0);
    check_eq("rst_rd_stb", {31'd0, rd_stb_o}, 32'd0);
    check_eq("rst_wr_addr", {24'd0, wr_addr_o}, 32'd0);
    check_eq("rst_wr_data", wr_data_o, 32'd0);
    check_eq("rst_rd_addr", {24'd0, rd_addr_o}, 32'd0);
    check_eq("rst_state", {29'd0, state_o}, 32'd0);
    rst_i = 1'b0;
    idle(2);

    // single write
    wbeat[0] = 8'h78; wbeat[1] = 8'h56; wbeat[2] = 8'h34; wbeat[3] = 8'h12;
    run_write(8'h06, 4);
    idle(2);

    // burst write wrapping the address
    for (int i = 0; i < 8; i++) wbeat[i] = 8'($urandom);
    run_write(8'hFF, 8);
    idle(1);

    // aborted write, then a normal one
    wbeat[0] = 8'hAA; wbeat[1] = 8'hBB;
    run_write(8'h09, 2);
    idle(1);
    for (int i = 0; i < 4; i++) wbeat[i] = 8'($urandom);
    run_write(8'h0A, 4);
    idle(2);

    // IDENT, VERSION, burst read
    run_read(8'h00, 6);
    idle(1);
    run_read(8'h01, 6);
    idle(1);
    run_read(8'h10, 12);
    idle(2);

    // reset during a read, then a clean read
    read_reset(8'h20);
    idle(2);
    run_read(8'h20, 6);
    idle(2);

    // randomized mix of complete, burst and aborted transactions
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 1);
      a    = 8'($urandom);
      if (t % 8 == 7) a = 8'hFF;
      if (kind == 0) begin
        nw = $urandom_range(1, 12);
        for (int i = 0; i < 16; i++) wbeat[i] = 8'($urandom);
        run_write(a, nw);
      end else begin
        nw = $urandom_range(1, 3);
        if ($urandom_range(0, 1) == 0) d = 6 * nw;
        else                           d = $urandom_range(1, 6 * nw - 1);
        run_read(a, d);
      end
      idle($urandom_range(1, 3));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
